// File: rtl/xyolo_write_ctrl_pkg.sv
// Shared definitions for the xyolo write-stage sequencer.
// Contents: FSM state encoding, strobe-tag bit positions, default pipeline
// latencies and a helper that packs a strobe tag.
package xyolo_ctrl_pkg;

    localparam int RD_LAT_DEF = 2;   // vread_enB -> pixel at xyolo input
    localparam int WR_LAT_DEF = 3;   // ld_res -> valid xyolo flow_out

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    // Strobe tag carried alongside every read through the delay line
    localparam int TAG_FIRST = 0;    // first pixel of a group
    localparam int TAG_LAST  = 1;    // last pixel of a group
    localparam int TAG_MP    = 2;    // group opens a maxpool window
    localparam int TAG_WR    = 3;    // group result gets written
    localparam int TAG_W     = 4;

    typedef logic [TAG_W-1:0] tag_t;

    function automatic tag_t make_tag(input logic first, input logic last,
                                      input logic mp, input logic wr);
        tag_t t;
        t            = {TAG_W{1'b0}};
        t[TAG_FIRST] = first;
        t[TAG_LAST]  = last;
        t[TAG_MP]    = mp;
        t[TAG_WR]    = wr;
        return t;
    endfunction

endpackage

// File: rtl/xyolo_write_ctrl_if.sv
// Bus between the write-stage sequencer and its surroundings.
// master: the sequencer (takes run + config, drives status, vread port B,
//         xyolo load strobes and vwrite port B).
// slave : the environment driving run/config and observing the outputs.
interface xyolo_write_ctrl_if
    import xyolo_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_W    = 10,
    parameter int VWRITE_ADDR_W = 10,
    parameter int CNT_W         = 16
);
    logic                     run;
    logic [CNT_W-1:0]         acc_len;
    logic [CNT_W-1:0]         n_out;
    logic                     maxpool;
    logic [MEM_ADDR_W-1:0]    rd_start;
    logic [VWRITE_ADDR_W-1:0] wr_start;
    logic                     busy;
    logic                     done;
    logic                     vread_enB;
    logic [MEM_ADDR_W-1:0]    vread_addrB;
    logic                     ld_acc;
    logic                     ld_mp;
    logic                     ld_res;
    logic                     vwrite_enB;
    logic [VWRITE_ADDR_W-1:0] vwrite_addrB;

    modport master (
        input  run, acc_len, n_out, maxpool, rd_start, wr_start,
        output busy, done, vread_enB, vread_addrB, ld_acc, ld_mp, ld_res,
               vwrite_enB, vwrite_addrB
    );

    modport slave (
        output run, acc_len, n_out, maxpool, rd_start, wr_start,
        input  busy, done, vread_enB, vread_addrB, ld_acc, ld_mp, ld_res,
               vwrite_enB, vwrite_addrB
    );
endinterface

// File: rtl/xyolo_write_ctrl_strobe_pipe.sv
// Fixed-depth shift register of strobe tags.
// Ports: clk, clr (synchronous clear), tag_i (tag entering stage 0),
//        stage_o (all stages, stage i holds the tag injected i+1 cycles ago),
//        empty_o (no tag is held before the output stage, so nothing remains
//        to be emitted after the current output).
module xyolo_strobe_pipe
    import xyolo_ctrl_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int W     = TAG_W
)(
    input  logic                  clk,
    input  logic                  clr,
    input  logic [W-1:0]          tag_i,
    output logic [DEPTH-1:0][W-1:0] stage_o,
    output logic                  empty_o
);
    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;

    // Shift every tag one stage further each cycle
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            stage_q <= {(DEPTH*W){1'b0}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;
    assign empty_o = (stage_q[DEPTH-2:0] == {((DEPTH-1)*W){1'b0}});

endmodule

// File: rtl/xyolo_write_ctrl.sv
// Internal sequencer of the xyolo write stage.
// Ports: clk, rst (synchronous, active high), bus (xyolo_write_ctrl_if master):
//   run/acc_len/n_out/maxpool/rd_start/wr_start in; busy/done status out;
//   vread_enB/vread_addrB, ld_acc/ld_mp/ld_res, vwrite_enB/vwrite_addrB out.
// One read per cycle is issued gap-free across all groups; each read pushes a
// tag into a delay line whose taps produce the load strobes and write enables.
module xyolo_write_ctrl
    import xyolo_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_W    = 10,
    parameter int VWRITE_ADDR_W = 10,
    parameter int CNT_W         = 16,
    parameter int RD_LAT        = RD_LAT_DEF,
    parameter int WR_LAT        = WR_LAT_DEF
)(
    input  logic               clk,
    input  logic               rst,
    xyolo_write_ctrl_if.master bus
);
    localparam int DEPTH = RD_LAT + 1 + WR_LAT;

    logic [1:0]               state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [CNT_W-1:0]         acc_len_q, acc_len_d;
    logic [CNT_W-1:0]         n_out_q, n_out_d;
    logic                     maxpool_q, maxpool_d;
    logic [CNT_W-1:0]         e_q, e_d;
    logic [CNT_W-1:0]         g_q, g_d;
    logic                     rd_en_q, rd_en_d;
    logic [MEM_ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic [VWRITE_ADDR_W-1:0] wr_nxt_q, wr_nxt_d;
    logic [VWRITE_ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic                     cfg_empty_s;
    logic                     elem_last_s;
    tag_t                     tag_in_s;
    logic [DEPTH-1:0][TAG_W-1:0] stage_s;
    logic                     pipe_empty_s;
    logic                     unused_stage_s;

    // Runs with nothing to compute finish without issuing any enable
    assign cfg_empty_s = (bus.acc_len == CNT_W'(0)) || (bus.n_out == CNT_W'(0)) ||
                         (bus.maxpool && (bus.n_out[1:0] != 2'd0));
    assign elem_last_s = (e_q == acc_len_q - CNT_W'(1));

    // Tag for the read currently on vread port B
    always_comb begin
        if (state_q == ST_READ) begin
            tag_in_s = make_tag(e_q == CNT_W'(0),
                                elem_last_s,
                                elem_last_s && maxpool_q && (g_q[1:0] == 2'd0),
                                elem_last_s && (!maxpool_q || (g_q[1:0] == 2'd3)));
        end else begin
            tag_in_s = {TAG_W{1'b0}};
        end
    end

    // Sequencer FSM, read counters and write-address generation
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        acc_len_d = acc_len_q;
        n_out_d   = n_out_q;
        maxpool_d = maxpool_q;
        e_d       = e_q;
        g_d       = g_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_nxt_d  = wr_nxt_q;
        wr_addr_d = wr_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    acc_len_d = bus.acc_len;
                    n_out_d   = bus.n_out;
                    maxpool_d = bus.maxpool;
                    e_d       = CNT_W'(0);
                    g_d       = CNT_W'(0);
                    wr_nxt_d  = bus.wr_start;
                    if (cfg_empty_s) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d   = ST_READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = bus.rd_start;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (elem_last_s) begin
                    e_d = CNT_W'(0);
                    if (g_q == n_out_q - CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        g_d       = g_q + CNT_W'(1);
                        rd_en_d   = 1'b1;
                        rd_addr_d = rd_addr_q + MEM_ADDR_W'(1);
                    end
                end else begin
                    e_d       = e_q + CNT_W'(1);
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + MEM_ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_s) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The tag one stage before the output writes next cycle: present its
        // address together with the enable, otherwise hold the last address.
        if (stage_s[DEPTH-2][TAG_WR]) begin
            wr_addr_d = wr_nxt_q;
            wr_nxt_d  = wr_nxt_q + VWRITE_ADDR_W'(1);
        end else begin
            wr_addr_d = wr_addr_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_len_q <= CNT_W'(0);
            n_out_q   <= CNT_W'(0);
            maxpool_q <= 1'b0;
            e_q       <= CNT_W'(0);
            g_q       <= CNT_W'(0);
            rd_en_q   <= 1'b0;
            rd_addr_q <= MEM_ADDR_W'(0);
            wr_nxt_q  <= VWRITE_ADDR_W'(0);
            wr_addr_q <= VWRITE_ADDR_W'(0);
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_len_q <= acc_len_d;
            n_out_q   <= n_out_d;
            maxpool_q <= maxpool_d;
            e_q       <= e_d;
            g_q       <= g_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_nxt_q  <= wr_nxt_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    xyolo_strobe_pipe #(
        .DEPTH (DEPTH),
        .W     (TAG_W)
    ) u_pipe (
        .clk     (clk),
        .clr     (rst),
        .tag_i   (tag_in_s),
        .stage_o (stage_s),
        .empty_o (pipe_empty_s)
    );

    // Only a few taps of the delay line drive outputs
    assign unused_stage_s = ^stage_s;

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.vread_enB    = rd_en_q;
    assign bus.vread_addrB  = rd_addr_q;
    assign bus.ld_acc       = stage_s[RD_LAT-1][TAG_FIRST];
    assign bus.ld_res       = stage_s[RD_LAT][TAG_LAST];
    assign bus.ld_mp        = stage_s[RD_LAT][TAG_MP];
    assign bus.vwrite_enB   = stage_s[DEPTH-1][TAG_WR];
    assign bus.vwrite_addrB = wr_addr_q;

endmodule

// File: doc/xyolo_write_ctrl.md
Name: xyolo_write_ctrl

Overview:
Internal sequencer for the xyolo write stage. Per run it drives the stage's internal-side ports: vread port B read addresses, xyolo load strobes (ld_acc, ld_mp, ld_res) and vwrite port B write addresses. It produces a gap-free stream of multiply-accumulate groups. It sits beside the write stage and is started by the same global_run pulse that starts the external address generators.

Parameters:
MEM_ADDR_W, 10, vread memory address width
VWRITE_ADDR_W, 10, vwrite memory address width
CNT_W, 16, width of group-length and output-count config fields
RD_LAT, 2, cycles from vread_enB to the pixel at the xyolo input (memory read plus output register)
WR_LAT, 3, cycles from the ld_res pulse to valid xyolo flow_out

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
run  in  1  start pulse (global_run)
acc_len  in  CNT_W  pixels per accumulation group
n_out  in  CNT_W  accumulation groups per run
maxpool  in  1  pool 4 consecutive groups into one written result
rd_start  in  MEM_ADDR_W  first vread address
wr_start  in  VWRITE_ADDR_W  first vwrite address
busy  out  1  sequence in progress
done  out  1  sequence complete (sticky)
vread_enB  out  1  vread read enable
vread_addrB  out  MEM_ADDR_W  vread read address
ld_acc  out  1  first pixel of a group at xyolo input
ld_mp  out  1  result is first of a maxpool window
ld_res  out  1  latch group result
vwrite_enB  out  1  vwrite write enable
vwrite_addrB  out  VWRITE_ADDR_W  vwrite write address

Behaviour:
- Reset (synchronous, priority over everything): every output is 0, done=0, the FSM is in IDLE, and all delay lines are cleared. Reset mid-run aborts the run with no further enables.
- Config is sampled on the run cycle and held internally; later config changes have no effect on the current run.
- FSM states: IDLE, READ, DRAIN, FIN.
  - IDLE + run: done<=0, busy<=1.
  - If acc_len==0 or n_out==0, or if maxpool=1 and n_out is not a multiple of 4: go to FIN (error-free empty run; done is set the next cycle and no enables are issued).
  - Otherwise go to READ.
- READ:
  - vread_enB=1 every cycle; vread_addrB starts at rd_start and increments by 1 each cycle, wrapping modulo 2^MEM_ADDR_W.
  - Element counter e runs 0..acc_len-1 and group counter g runs 0..n_out-1. There are no bubbles between groups.
  - After n_out*acc_len reads, go to DRAIN.
- Strobe timing, with reads issued at cycle t:
  - ld_acc=1 at t+RD_LAT for the read with e==0.
  - ld_res=1 at t+RD_LAT+1 for the read with e==acc_len-1.
  - ld_mp accompanies that ld_res when maxpool=1 and g%4==0; it is 0 when maxpool=0.
- acc_len==1: ld_acc and ld_res fire for the same read, one cycle apart, every cycle.
- Writes:
  - vwrite_enB=1 at WR_LAT cycles after each ld_res when maxpool=0.
  - When maxpool=1, writes follow only the ld_res with g%4==3.
  - vwrite_addrB starts at wr_start and increments by 1 per write, wrapping modulo 2^VWRITE_ADDR_W.
  - vwrite_addrB holds its last value while vwrite_enB=0.
- Implementation: a strobe delay line of depth RD_LAT+1+WR_LAT carrying {first, last, mp, wr} tags.
- DRAIN: wait until the delay line is empty, i.e. the last write has been issued, then go to FIN.
- FIN: busy<=0, done<=1, go to IDLE. done stays high until the next accepted run or reset.
- A run while busy=1 is ignored. A run in the same cycle as FIN is accepted on the following cycle only if it is still asserted.
- Total latency: the last vwrite_enB occurs at run + 1 + n_out*acc_len - 1 + RD_LAT + 1 + WR_LAT. done rises 2 cycles later.

Decomposition:
- Shared package xyolo_ctrl_pkg:
  - FSM state encoding (IDLE=0, READ=1, DRAIN=2, FIN=3);
  - strobe-tag bit indices;
  - default RD_LAT/WR_LAT.
- One natural sub-module, xyolo_strobe_pipe: a parameterised-depth shift register of tag vectors with a synchronous clear and an empty flag.

Test Plan:
- acc_len=3, n_out=2, maxpool=0, rd_start=0x10, wr_start=0x20 -> vread_addrB 0x10..0x15 on 6 consecutive cycles; ld_acc twice, 3 cycles apart; ld_res 3 cycles apart; writes at 0x20 and 0x21; done 2 cycles after the last write.
- acc_len=1, n_out=8, maxpool=1 -> ld_res every cycle for 8 cycles; ld_mp on groups 0 and 4; exactly 2 vwrite_enB pulses at wr_start and wr_start+1.
- rd_start=0x3FE, acc_len=4, n_out=1 -> read addresses 0x3FE, 0x3FF, 0x000, 0x001; one write.
- n_out=0, and separately maxpool=1 with n_out=6 -> no vread_enB or vwrite_enB; done=1 two cycles after run.
- rst asserted 4 cycles into a run of acc_len=9 -> all outputs 0 the next cycle, no writes afterwards, done=0; a fresh run afterwards completes normally.
- run pulsed again while busy -> ignored: read and write counts are unchanged and done rises exactly once.
